mem_wb_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage: captures load data or ALU result, extracts/extends sub-word

---
 rtl/mem_wb_stage_pkg.sv | 18 +
 rtl/mem_wb_stage_load_extract.sv | 33 +++
 rtl/mem_wb_stage.sv | 91 +++++++++
 tb/tb_mem_wb_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: load encodings, default widths and the writeback entry shared by the MEM/WB slice
package mem_wb_stage_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RADDR_W_DEF = 5;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LD = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef struct packed {
    logic [RADDR_W_DEF-1:0] rd;
    logic regwrite;
    logic [XLEN_DEF-1:0] result;
    logic misalign;
  } wb_entry_t;
endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: picks the byte/half/word/double at the byte offset of an aligned memory word,
// sign- or zero-extends it and flags offsets not aligned to the access size
module load_extract
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data,
  output logic             misalign
);
  logic [2:0] f;
  logic [XLEN-1:0] sh;
  logic [63:0] s, ext;
  logic u;
  // Encodings the datapath cannot perform fall back to the natural word size
  assign f = (XLEN == 64) ? ((funct3 == 3'b111) ? F3_LD : funct3)
           : ((funct3[1:0] == 2'b11 || funct3 == F3_LWU) ? F3_LW : funct3);
  assign u = f[2];
  assign sh = rdata >> {offset, 3'b000};
  assign s = 64'(sh);
  assign ext = (f[1:0] == 2'b00) ? {{56{s[7] & ~u}}, s[7:0]}
             : (f[1:0] == 2'b01) ? {{48{s[15] & ~u}}, s[15:0]}
             : (f[1:0] == 2'b10) ? {{32{s[31] & ~u}}, s[31:0]}
             : s;
  assign data = ext[XLEN-1:0];
  assign misalign = (f[1:0] == 2'b01 && offset[0])
                  | (f[1:0] == 2'b10 && |offset[1:0])
                  | (f[1:0] == 2'b11 && |offset);
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with load extraction, valid/ready handshake,
// optional 2-entry skid buffer, flush, x0 write suppression and a forwarding tap
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter bit SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_regwrite,
  input  logic               in_memtoreg,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_regwrite,
  output logic [XLEN-1:0]    wb_result,
  output logic               wb_misalign,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic regwrite;
    logic [XLEN-1:0] result;
    logic misalign;
  } entry_t;
  logic [1:0] state;
  entry_t cap, main, skid;
  logic [XLEN-1:0] ld_data;
  logic ld_mis, accept, drain, load_main, load_skid;
  load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extract (
    .funct3  (in_funct3),
    .offset  (in_alu_result[OFF_W-1:0]),
    .rdata   (mem_rdata),
    .data    (ld_data),
    .misalign(ld_mis)
  );
  assign cap.rd = in_rd;
  assign cap.regwrite = in_regwrite;
  assign cap.misalign = in_memtoreg & ld_mis;
  assign cap.result = (in_memtoreg & ~ld_mis) ? ld_data : in_alu_result;
  assign out_valid = state != EMPTY;
  assign in_ready = ~reset & (SKID_EN ? state != FULL : out_ready | ~out_valid);
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  // State doubles as the occupancy count, so main refills from skid whenever FULL drains
  assign load_main = (accept & (~out_valid | drain)) | (state == FULL & drain);
  assign load_skid = accept & out_valid & ~drain;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      main <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state + 2'(accept) - 2'(drain);
      if (load_main) main <= (state == FULL) ? skid : cap;
    end
  end
  generate
    if (SKID_EN) begin : g_skid
      always_ff @(posedge clk or posedge reset) begin
        if (reset) skid <= '0;
        else if (!flush && load_skid) skid <= cap;
      end
    end else begin : g_noskid
      assign skid = '0;
    end
  endgenerate
  assign wb_rd = out_valid ? main.rd : '0;
  assign wb_result = out_valid ? main.result : '0;
  assign wb_misalign = out_valid & main.misalign;
  assign wb_regwrite = out_valid & main.regwrite & |main.rd & ~main.misalign;
  assign fwd_valid = wb_regwrite;
  assign fwd_rd = wb_rd;
  assign fwd_data = wb_result;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table, hand-built corner sequences and a random handshake run
// scored against a queue-based model of the stage
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_regwrite, in_memtoreg, out_valid, out_ready;
  logic wb_regwrite, wb_misalign, fwd_valid;
  logic [2:0] in_funct3;
  logic [4:0] in_rd, wb_rd, fwd_rd;
  logic [31:0] in_alu_result, mem_rdata, wb_result, fwd_data;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .wb_misalign(wb_misalign), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [31:0] res;
    logic rw;
    logic mis;
    logic [4:0] rd;
  } qe_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [2:0] f3;
    logic m;
    logic [4:0] rd;
    logic rw;
    logic [31:0] res;
    logic wrw;
    logic mis;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  // Writeback outcome from the load rules in plain arithmetic
  function automatic qe_t model(input logic [31:0] alu, input logic [31:0] rdata,
                                input logic [2:0] f3, input logic m, input logic [4:0] rd,
                                input logic rw);
    qe_t q;
    logic [2:0] f;
    int off, sz;
    longint mask, v;
    q.rd = rd;
    q.res = alu;
    q.mis = 1'b0;
    if (m) begin
      f = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? f3 : 3'd2;
      off = int'(alu % 4);
      sz = 1 << f[1:0];
      if (off % sz != 0) q.mis = 1'b1;
      else begin
        mask = (longint'(1) << (8 * sz)) - 1;
        v = (longint'(rdata) >> (8 * off)) & mask;
        if (f[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        q.res = v[31:0];
      end
    end
    q.rw = rw && rd != 0 && !q.mis;
    return q;
  endfunction

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] f3, input logic m, input logic [4:0] rd, input logic rw);
    in_valid = v;
    in_alu_result = alu;
    mem_rdata = rdata;
    in_funct3 = f3;
    in_memtoreg = m;
    in_rd = rd;
    in_regwrite = rw;
  endtask

  vec_t vecs[12];
  qe_t sb[$];
  qe_t e;
  logic exp_rdy;

  initial begin
    vecs[0]  = '{32'h1234_5678, 32'h0,         3'd0, 1'b0, 5'd5,  1'b1, 32'h1234_5678, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000_1001, 32'h8081_F2F3, 3'd0, 1'b1, 5'd6,  1'b1, 32'hFFFF_FFF2, 1'b1, 1'b0};
    vecs[2]  = '{32'h0000_1003, 32'h8081_F2F3, 3'd4, 1'b1, 5'd7,  1'b1, 32'h0000_0080, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_1002, 32'h8081_F2F3, 3'd1, 1'b1, 5'd8,  1'b1, 32'hFFFF_8081, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_1000, 32'h8081_F2F3, 3'd5, 1'b1, 5'd9,  1'b1, 32'h0000_F2F3, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_1000, 32'h8081_F2F3, 3'd2, 1'b1, 5'd10, 1'b1, 32'h8081_F2F3, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_1002, 32'h8081_F2F3, 3'd2, 1'b1, 5'd11, 1'b1, 32'h0000_1002, 1'b0, 1'b1};
    vecs[7]  = '{32'hCAFE_0001, 32'h8081_F2F3, 3'd0, 1'b0, 5'd0,  1'b1, 32'hCAFE_0001, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_1001, 32'h8081_F2F3, 3'd1, 1'b1, 5'd12, 1'b1, 32'h0000_1001, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_1000, 32'h8081_F2F3, 3'd3, 1'b1, 5'd13, 1'b1, 32'h8081_F2F3, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0003, 32'h8081_F2F3, 3'd1, 1'b0, 5'd14, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
    vecs[11] = '{32'h0000_1000, 32'h8081_F2F3, 3'd0, 1'b1, 5'd15, 1'b0, 32'hFFFF_FFF3, 1'b0, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 5'd0, 1'b0);
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_wb_result", 64'(wb_result), 64'd0);
    chk("reset_wb_regwrite", 64'(wb_regwrite), 64'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].alu, vecs[i].rdata, vecs[i].f3, vecs[i].m, vecs[i].rd, vecs[i].rw);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(wb_result), 64'(vecs[i].res));
      chk($sformatf("vec%0d_regwrite", i), 64'(wb_regwrite), 64'(vecs[i].wrw));
      chk($sformatf("vec%0d_misalign", i), 64'(wb_misalign), 64'(vecs[i].mis));
      chk($sformatf("vec%0d_rd", i), 64'(wb_rd), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_fwd", i), {31'd0, fwd_valid, fwd_data}, {31'd0, vecs[i].wrw, vecs[i].res});
      @(negedge clk) in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: A and B fill the stage, C must wait until A drains
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 3'd0, 1'b0, 5'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hB, 32'h0, 3'd0, 1'b0, 5'd2, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'hC, 32'h0, 3'd0, 1'b0, 5'd3, 1'b1);
    #1;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_a", 64'(wb_result), 64'hA);
    @(negedge clk);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second_b", 64'(wb_result), 64'hB);
    chk("bp_ready_again", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_third_c", 64'(wb_result), 64'hC);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a new instruction offered
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 3'd0, 1'b0, 5'd4, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h22, 32'h0, 3'd0, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h33, 32'h0, 3'd0, 1'b0, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_same_cycle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_no_write", 64'(wb_regwrite), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_stays_empty", 64'(out_valid), 64'd0);

    // Reset with one entry held
    @(negedge clk);
    drive(1'b1, 32'h55, 32'h0, 3'd0, 1'b0, 5'd7, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_one", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", {fwd_data, wb_rd, wb_regwrite, fwd_valid, in_ready}, 64'd0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("after_midreset_ready", 64'(in_ready), 64'd1);

    // Random handshake run against the queue model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      #1;
      exp_rdy = sb.size() < 2;
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("rnd_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        e = sb[0];
        chk("rnd_entry", {wb_result, 16'd0, 5'(wb_rd), wb_regwrite, wb_misalign, fwd_valid},
            {e.res, 16'd0, e.rd, e.rw, e.mis, e.rw});
      end
      if (flush) sb.delete();
      else begin
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (in_valid && exp_rdy)
          sb.push_back(model(in_alu_result, mem_rdata, in_funct3, in_memtoreg, in_rd, in_regwrite));
      end
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
